// File: rtl/sync_fifo_prog_pkg.sv
// Shared types and helpers for the programmable single-clock FIFO.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus of the FIFO: data path, control, thresholds and status.
interface sync_fifo_prog_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              flush;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  af_thresh;
    logic [CNT_W-1:0]  ae_thresh;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              err_clr;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, w_en, w_data, r_en, af_thresh, ae_thresh, err_clr,
        input  r_data, r_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, w_en, w_data, r_en, af_thresh, ae_thresh, err_clr,
        output r_data, r_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog_mem.sv
// Storage array: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with STD/FWFT read modes, occupancy, programmable almost
// flags, synchronous flush and sticky overflow/underflow.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter int         DEPTH  = 16,
    parameter fifo_mode_e MODE   = FIFO_STD
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_prog_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = fifo_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("sync_fifo_prog: DEPTH must be a power of two and >= 4");
    end

    logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              full_w, empty_w, wr_acc, rd_acc, ovf_set, unf_set;
    logic [DATA_W-1:0] mem_rdata;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // Flush swallows both requests, so neither an access nor an error can occur.
    assign wr_acc  = bus.w_en && !full_w  && !bus.flush;
    assign rd_acc  = bus.r_en && !empty_w && !bus.flush;
    assign ovf_set = bus.w_en &&  full_w  && !bus.flush;
    assign unf_set = bus.r_en &&  empty_w && !bus.flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // A new error in the clearing cycle must survive the clear.
        ovf_d = ovf_set ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
        unf_d = unf_set ? 1'b1 : (bus.err_clr ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i (bus.w_data),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_W-1:0] r_data_q, r_data_d;
        logic              r_valid_q, r_valid_d;

        always_comb begin
            r_data_d  = rd_acc ? mem_rdata : r_data_q;
            r_valid_d = rd_acc;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_data_q  <= r_data_d;
                r_valid_q <= r_valid_d;
            end
        end

        assign bus.r_data  = r_data_q;
        assign bus.r_valid = r_valid_q;
    end else begin : g_fwft
        assign bus.r_data  = empty_w ? '0 : mem_rdata;
        assign bus.r_valid = !empty_w;
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
